alu_seq: RTL and testbench



---
 rtl/alu_seq.sv | 196 +++++++++++++++++++
 tb/tb_alu_seq.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq: 8-bit execution unit, single-cycle ALU ops plus shift-add MUL.
// Produces the result, flags and a flag-write strobe for the flag register.
package alu_seq_pkg;
    typedef struct packed {
        logic carry;
        logic zero;
        logic sign;
        logic overflow;
    } struct_alu_flag_t;

    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_ADC = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_SBB = 4'h3;
    localparam logic [3:0] OP_AND = 4'h4;
    localparam logic [3:0] OP_OR  = 4'h5;
    localparam logic [3:0] OP_XOR = 4'h6;
    localparam logic [3:0] OP_NOT = 4'h7;
    localparam logic [3:0] OP_SHL = 4'h8;
    localparam logic [3:0] OP_SHR = 4'h9;
    localparam logic [3:0] OP_ROL = 4'hA;
    localparam logic [3:0] OP_ROR = 4'hB;
    localparam logic [3:0] OP_MUL = 4'hC;
endpackage

module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              iclk,
    input  logic              irst,
    input  logic              istart,
    input  logic              iabort,
    input  logic [3:0]        iop,
    input  logic [DATA_W-1:0] ia,
    input  logic [DATA_W-1:0] ib,
    input  logic              icarry,
    output logic              obusy,
    output logic              odone,
    output logic [DATA_W-1:0] oresult,
    output logic [DATA_W-1:0] oresult_hi,
    output struct_alu_flag_t  oflag,
    output logic              oflag_we
);

    localparam int CW = $clog2(DATA_W);
    localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

    typedef enum logic [0:0] {
        IDLE,
        MUL
    } state_t;

    state_t            state;
    logic [CW-1:0]     cnt;
    logic [DATA_W-1:0] mcand;
    logic [DATA_W-1:0] p_hi;
    logic [DATA_W-1:0] p_lo;

    logic              cin;
    logic [DATA_W:0]   sum;
    logic [DATA_W:0]   diff;
    logic [DATA_W-1:0] alu_res;
    struct_alu_flag_t  alu_flg;
    logic              alu_we;

    logic [DATA_W:0]   acc;
    logic [DATA_W-1:0] nhi;
    logic [DATA_W-1:0] nlo;
    struct_alu_flag_t  mul_flg;

    // Single-cycle result and flags, computed from the operands at accept
    always_comb begin
        cin     = (iop == OP_ADC || iop == OP_SBB) ? icarry : 1'b0;
        sum     = {1'b0, ia} + {1'b0, ib} + {{DATA_W{1'b0}}, cin};
        diff    = {1'b0, ia} - {1'b0, ib} - {{DATA_W{1'b0}}, cin};
        alu_res = ia;
        alu_flg = '0;
        alu_we  = 1'b1;
        case (iop)
            OP_ADD, OP_ADC: begin
                alu_res          = sum[DATA_W-1:0];
                alu_flg.carry    = sum[DATA_W];
                alu_flg.overflow = (ia[DATA_W-1] == ib[DATA_W-1]) &&
                                   (sum[DATA_W-1] != ia[DATA_W-1]);
            end
            OP_SUB, OP_SBB: begin
                alu_res          = diff[DATA_W-1:0];
                alu_flg.carry    = diff[DATA_W];
                alu_flg.overflow = (ia[DATA_W-1] != ib[DATA_W-1]) &&
                                   (diff[DATA_W-1] != ia[DATA_W-1]);
            end
            OP_AND: alu_res = ia & ib;
            OP_OR:  alu_res = ia | ib;
            OP_XOR: alu_res = ia ^ ib;
            OP_NOT: alu_res = ~ia;
            OP_SHL: begin
                alu_res       = {ia[DATA_W-2:0], 1'b0};
                alu_flg.carry = ia[DATA_W-1];
            end
            OP_SHR: begin
                alu_res       = {1'b0, ia[DATA_W-1:1]};
                alu_flg.carry = ia[0];
            end
            OP_ROL: begin
                alu_res       = {ia[DATA_W-2:0], ia[DATA_W-1]};
                alu_flg.carry = ia[DATA_W-1];
            end
            OP_ROR: begin
                alu_res       = {ia[0], ia[DATA_W-1:1]};
                alu_flg.carry = ia[0];
            end
            default: alu_we = 1'b0;
        endcase
        alu_flg.zero = (alu_res == '0);
        alu_flg.sign = alu_res[DATA_W-1];
    end

    // One shift-add step: add multiplicand on lsb, shift {acc, lo} right
    always_comb begin
        acc = {1'b0, p_hi} + (p_lo[0] ? {1'b0, mcand} : '0);
        nhi = acc[DATA_W:1];
        nlo = {acc[0], p_lo[DATA_W-1:1]};
        mul_flg.carry    = |nhi;
        mul_flg.overflow = |nhi;
        mul_flg.zero     = ~|{nhi, nlo};
        mul_flg.sign     = nhi[DATA_W-1];
    end

    // Control FSM with registered outputs; abort beats completion
    always_ff @(posedge iclk or posedge irst) begin
        if (irst) begin
            state      <= IDLE;
            cnt        <= '0;
            mcand      <= '0;
            p_hi       <= '0;
            p_lo       <= '0;
            obusy      <= 1'b0;
            odone      <= 1'b0;
            oflag_we   <= 1'b0;
            oresult    <= '0;
            oresult_hi <= '0;
            oflag      <= '0;
        end else begin
            odone    <= 1'b0;
            oflag_we <= 1'b0;
            case (state)
                IDLE: begin
                    if (istart) begin
                        if (iop == OP_MUL) begin
                            state <= MUL;
                            obusy <= 1'b1;
                            mcand <= ia;
                            p_hi  <= '0;
                            p_lo  <= ib;
                            cnt   <= '0;
                        end else begin
                            oresult    <= alu_res;
                            oresult_hi <= '0;
                            odone      <= 1'b1;
                            if (alu_we) begin
                                oflag    <= alu_flg;
                                oflag_we <= 1'b1;
                            end
                        end
                    end
                end
                MUL: begin
                    if (iabort) begin
                        state <= IDLE;
                        obusy <= 1'b0;
                        cnt   <= '0;
                    end else if (cnt == LAST) begin
                        state      <= IDLE;
                        obusy      <= 1'b0;
                        cnt        <= '0;
                        p_hi       <= nhi;
                        p_lo       <= nlo;
                        oresult    <= nlo;
                        oresult_hi <= nhi;
                        oflag      <= mul_flg;
                        odone      <= 1'b1;
                        oflag_we   <= 1'b1;
                    end else begin
                        p_hi <= nhi;
                        p_lo <= nlo;
                        cnt  <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed self-checking bench for alu_seq.
// Hand-computed vectors for ALU ops, MUL timing, abort, reserved op and reset.
module tb_alu_seq;
    import alu_seq_pkg::*;

    logic             iclk;
    logic             irst;
    logic             istart;
    logic             iabort;
    logic [3:0]       iop;
    logic [7:0]       ia;
    logic [7:0]       ib;
    logic             icarry;
    logic             obusy;
    logic             odone;
    logic [7:0]       oresult;
    logic [7:0]       oresult_hi;
    struct_alu_flag_t oflag;
    logic             oflag_we;
    logic [3:0]       fv;

    int checks = 0;
    int failures = 0;

    assign fv = oflag;

    alu_seq #(.DATA_W(8)) dut (
        .iclk(iclk), .irst(irst), .istart(istart), .iabort(iabort),
        .iop(iop), .ia(ia), .ib(ib), .icarry(icarry),
        .obusy(obusy), .odone(odone), .oresult(oresult),
        .oresult_hi(oresult_hi), .oflag(oflag), .oflag_we(oflag_we)
    );

    initial iclk = 1'b0;
    always #5 iclk = ~iclk;

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge iclk);
        #1;
    endtask

    task automatic issue(input logic [3:0] op, input logic [7:0] a,
                         input logic [7:0] b);
        istart = 1'b1;
        iop    = op;
        ia     = a;
        ib     = b;
        tick();
        istart = 1'b0;
    endtask

    task automatic chk_done(input string tag, input logic [7:0] res,
                            input logic [7:0] hi, input logic [3:0] flg,
                            input logic we);
        chk({tag, "_done"}, {15'd0, odone}, 16'd1);
        chk({tag, "_we"}, {15'd0, oflag_we}, {15'd0, we});
        chk({tag, "_res"}, {oresult_hi, oresult}, {hi, res});
        chk({tag, "_flag"}, {12'd0, fv}, {12'd0, flg});
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_done0"}, {15'd0, odone}, 16'd0);
        chk({tag, "_we0"}, {15'd0, oflag_we}, 16'd0);
    endtask

    initial begin
        irst = 1'b1; istart = 1'b0; iabort = 1'b0;
        iop = 4'h0; ia = 8'h00; ib = 8'h00; icarry = 1'b0;
        tick();
        tick();
        chk("rst_ctl", {13'd0, obusy, odone, oflag_we}, 16'd0);
        chk("rst_res", {oresult_hi, oresult}, 16'h0000);
        chk("rst_flag", {12'd0, fv}, 16'd0);
        @(negedge iclk);
        irst = 1'b0;
        tick();

        issue(OP_ADD, 8'h7F, 8'h01);
        chk_done("add", 8'h80, 8'h00, 4'b0011, 1'b1);
        tick();
        chk_quiet("add_after");

        icarry = 1'b1;
        issue(OP_ADC, 8'hFF, 8'h00);
        chk_done("adc", 8'h00, 8'h00, 4'b1100, 1'b1);
        icarry = 1'b0;
        issue(OP_SUB, 8'h00, 8'h01);
        chk_done("sub", 8'hFF, 8'h00, 4'b1010, 1'b1);
        icarry = 1'b1;
        issue(OP_SBB, 8'h10, 8'h0F);
        chk_done("sbb", 8'h00, 8'h00, 4'b0100, 1'b1);
        icarry = 1'b0;
        tick();

        issue(OP_MUL, 8'h10, 8'h10);
        chk("mul1_e0", {14'd0, obusy, odone}, 16'b10);
        for (int k = 1; k < 8; k++) begin
            tick();
            chk("mul1_iter", {14'd0, obusy, odone}, 16'b10);
        end
        tick();
        chk("mul1_busy", {15'd0, obusy}, 16'd0);
        chk_done("mul1", 8'h00, 8'h01, 4'b1001, 1'b1);
        tick();
        chk_quiet("mul1_after");

        issue(OP_MUL, 8'h0F, 8'h11);
        tick();
        tick();
        istart = 1'b1; iop = OP_ADD; ia = 8'h01; ib = 8'h01;
        tick();
        istart = 1'b0;
        chk("mul2_ign", {14'd0, obusy, odone}, 16'b10);
        for (int k = 4; k < 8; k++) tick();
        chk("mul2_pre", {14'd0, obusy, odone}, 16'b10);
        tick();
        chk_done("mul2", 8'hFF, 8'h00, 4'b0000, 1'b1);
        issue(OP_ADD, 8'h01, 8'h02);
        chk_done("b2b", 8'h03, 8'h00, 4'b0000, 1'b1);
        tick();

        issue(OP_MUL, 8'h20, 8'h20);
        tick();
        tick();
        tick();
        iabort = 1'b1;
        tick();
        iabort = 1'b0;
        chk("abort_busy", {14'd0, obusy, odone}, 16'b00);
        chk("abort_res", {oresult_hi, oresult}, 16'h0003);
        for (int k = 0; k < 6; k++) begin
            tick();
            chk_quiet("abort_later");
        end

        issue(OP_SHL, 8'h81, 8'h00);
        chk_done("shl", 8'h02, 8'h00, 4'b1000, 1'b1);
        issue(OP_ROR, 8'h01, 8'h00);
        chk_done("ror", 8'h80, 8'h00, 4'b1010, 1'b1);
        issue(4'hE, 8'h5A, 8'h33);
        chk_done("rsv", 8'h5A, 8'h00, 4'b1010, 1'b0);
        tick();

        issue(OP_MUL, 8'hFF, 8'hFF);
        tick();
        tick();
        irst = 1'b1;
        #1;
        chk("rstmid_ctl", {13'd0, obusy, odone, oflag_we}, 16'd0);
        chk("rstmid_res", {oresult_hi, oresult}, 16'h0000);
        chk("rstmid_flag", {12'd0, fv}, 16'd0);
        @(negedge iclk);
        irst = 1'b0;
        tick();
        chk_quiet("rstmid_after");

        iabort = 1'b1;
        issue(OP_ADD, 8'h05, 8'h03);
        iabort = 1'b0;
        chk_done("post_add", 8'h08, 8'h00, 4'b0000, 1'b1);
        tick();
        chk_quiet("post_add_after");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
